// File: rtl/conv_operand_loader.sv
// conv_operand_loader: fetches one input tile and (optionally) one kernel from
// two single-port BRAMs into flattened operand registers, then pulses
// conv_start. The kernel is cached across tiles unless a reload is requested.
module conv_operand_loader #(
  parameter int TILE_SIZE     = 4,
  parameter int KERNEL_SIZE   = 3,
  parameter int CHANNELS      = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int KERNEL_WIDTH  = 8,
  parameter int IN_ADDR_WIDTH = 15,
  parameter int K_ADDR_WIDTH  = 8,
  parameter int BRAM_LATENCY  = 1,
  localparam int IN_LEN = TILE_SIZE * TILE_SIZE * CHANNELS,
  localparam int K_LEN  = KERNEL_SIZE * KERNEL_SIZE * CHANNELS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_start,
  input  logic [IN_ADDR_WIDTH-1:0]       tile_base_addr,
  input  logic [K_ADDR_WIDTH-1:0]        kernel_base_addr,
  input  logic                           reload_kernel,
  output logic                           in_en,
  output logic [IN_ADDR_WIDTH-1:0]       in_addr,
  input  logic [DATA_WIDTH-1:0]          in_dout,
  output logic                           k_en,
  output logic [K_ADDR_WIDTH-1:0]        k_addr,
  input  logic [KERNEL_WIDTH-1:0]        k_dout,
  output logic [IN_LEN*DATA_WIDTH-1:0]   flatten_input,
  output logic [K_LEN*KERNEL_WIDTH-1:0]  flatten_kernel,
  output logic                           operands_valid,
  output logic                           conv_start,
  input  logic                           operands_ack,
  output logic                           busy
);

  localparam int MAX_LEN = (IN_LEN > K_LEN) ? IN_LEN : K_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_READY = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;          // index of the issue currently on the BRAM ports
  logic [CNT_W-1:0] last_issue;   // N-1 for the current load
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       drain_cnt;
  logic             do_k;
  logic             kernel_cached;
  logic             do_k_now;

  // Valid-tag delay line matching the BRAM read latency
  logic             tag_in  [BRAM_LATENCY];
  logic             tag_k   [BRAM_LATENCY];
  logic [CNT_W-1:0] tag_idx [BRAM_LATENCY];

  logic             cap_in;
  logic             cap_k;
  logic [CNT_W-1:0] cap_idx;
  logic [IN_LEN-1:0] in_hit;
  logic [K_LEN-1:0]  k_hit;

  assign do_k_now = reload_kernel | ~kernel_cached;
  assign cnt_next = cnt + CNT_W'(1);
  assign busy     = (state != S_IDLE);

  assign cap_in  = tag_in[BRAM_LATENCY-1];
  assign cap_k   = tag_k[BRAM_LATENCY-1];
  assign cap_idx = tag_idx[BRAM_LATENCY-1];

  // Per-slot write strobes: element i lands in slot LEN-1-i (first element in MSB)
  generate
    for (genvar gi = 0; gi < IN_LEN; gi++) begin : g_in_hit
      assign in_hit[gi] = cap_in && (cap_idx == CNT_W'(gi));
    end
    for (genvar gi = 0; gi < K_LEN; gi++) begin : g_k_hit
      assign k_hit[gi] = cap_k && (cap_idx == CNT_W'(gi));
    end
  endgenerate

  // Control FSM: accept, issue N addresses, drain the BRAM pipeline, hand off
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      last_issue     <= '0;
      drain_cnt      <= '0;
      do_k           <= 1'b0;
      kernel_cached  <= 1'b0;
      in_en          <= 1'b0;
      in_addr        <= '0;
      k_en           <= 1'b0;
      k_addr         <= '0;
      operands_valid <= 1'b0;
      conv_start     <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            state      <= S_FETCH;
            cnt        <= '0;
            do_k       <= do_k_now;
            last_issue <= do_k_now ? CNT_W'(MAX_LEN - 1) : CNT_W'(IN_LEN - 1);
            in_en      <= 1'b1;
            in_addr    <= tile_base_addr;
            k_en       <= do_k_now;
            if (do_k_now) begin
              k_addr <= kernel_base_addr;
            end
          end
        end
        S_FETCH: begin
          if (cnt == last_issue) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
            in_en     <= 1'b0;
            k_en      <= 1'b0;
          end else begin
            cnt     <= cnt_next;
            in_addr <= in_addr + IN_ADDR_WIDTH'(1);
            in_en   <= (cnt_next < CNT_W'(IN_LEN));
            if (do_k) begin
              k_addr <= k_addr + K_ADDR_WIDTH'(1);
            end
            k_en    <= do_k && (cnt_next < CNT_W'(K_LEN));
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 2'(BRAM_LATENCY - 1)) begin
            state          <= S_READY;
            operands_valid <= 1'b1;
            conv_start     <= 1'b1;
            if (do_k) begin
              kernel_cached <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: begin
          if (operands_ack) begin
            state          <= S_IDLE;
            operands_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Shift issue tags along so each one meets its data at the BRAM output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < BRAM_LATENCY; s++) begin
        tag_in[s]  <= 1'b0;
        tag_k[s]   <= 1'b0;
        tag_idx[s] <= '0;
      end
    end else begin
      for (int s = BRAM_LATENCY - 1; s > 0; s--) begin
        tag_in[s]  <= tag_in[s-1];
        tag_k[s]   <= tag_k[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
      tag_in[0]  <= (state == S_FETCH) && in_en;
      tag_k[0]   <= (state == S_FETCH) && k_en;
      tag_idx[0] <= cnt;
    end
  end

  // Capture returning BRAM data into the flattened operand registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flatten_input  <= '0;
      flatten_kernel <= '0;
    end else begin
      for (int s = 0; s < IN_LEN; s++) begin
        if (in_hit[s]) begin
          flatten_input[(IN_LEN-1-s)*DATA_WIDTH +: DATA_WIDTH] <= in_dout;
        end
      end
      for (int s = 0; s < K_LEN; s++) begin
        if (k_hit[s]) begin
          flatten_kernel[(K_LEN-1-s)*KERNEL_WIDTH +: KERNEL_WIDTH] <= k_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_operand_loader.sv
// Directed bench for conv_operand_loader: a default instance (latency 1) and a
// small instance (2x2x1 tile, 3x3x1 kernel, latency 3), BRAM contents mem[a]=a.
module tb_conv_operand_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: defaults ----------------
  logic         a_ls = 1'b0, a_rk = 1'b0, a_ack = 1'b0;
  logic [14:0]  a_tb = '0;
  logic [7:0]   a_kb = '0;
  logic         a_in_en, a_k_en, a_valid, a_cs, a_busy;
  logic [14:0]  a_in_addr;
  logic [7:0]   a_k_addr;
  logic [7:0]   a_in_dout = '0, a_k_dout = '0;
  logic [383:0] a_fi;
  logic [215:0] a_fk;

  conv_operand_loader dut_a (
    .clk(clk), .reset(rst_n), .load_start(a_ls),
    .tile_base_addr(a_tb), .kernel_base_addr(a_kb), .reload_kernel(a_rk),
    .in_en(a_in_en), .in_addr(a_in_addr), .in_dout(a_in_dout),
    .k_en(a_k_en), .k_addr(a_k_addr), .k_dout(a_k_dout),
    .flatten_input(a_fi), .flatten_kernel(a_fk),
    .operands_valid(a_valid), .conv_start(a_cs), .operands_ack(a_ack), .busy(a_busy)
  );

  // Latency-1 BRAM models
  always @(posedge clk) begin
    if (a_in_en) a_in_dout <= a_in_addr[7:0];
    if (a_k_en)  a_k_dout  <= a_k_addr;
  end

  // ---------------- instance B: small, latency 3 ----------------
  logic         b_ls = 1'b0, b_rk = 1'b0, b_ack = 1'b0;
  logic [14:0]  b_tb = '0;
  logic [7:0]   b_kb = '0;
  logic         b_in_en, b_k_en, b_valid, b_cs, b_busy;
  logic [14:0]  b_in_addr;
  logic [7:0]   b_k_addr;
  logic [7:0]   b_in_dout = '0, b_k_dout = '0;
  logic [7:0]   b_in_p0 = '0, b_in_p1 = '0, b_k_p0 = '0, b_k_p1 = '0;
  logic [31:0]  b_fi;
  logic [71:0]  b_fk;

  conv_operand_loader #(
    .TILE_SIZE(2), .KERNEL_SIZE(3), .CHANNELS(1), .BRAM_LATENCY(3)
  ) dut_b (
    .clk(clk), .reset(rst_n), .load_start(b_ls),
    .tile_base_addr(b_tb), .kernel_base_addr(b_kb), .reload_kernel(b_rk),
    .in_en(b_in_en), .in_addr(b_in_addr), .in_dout(b_in_dout),
    .k_en(b_k_en), .k_addr(b_k_addr), .k_dout(b_k_dout),
    .flatten_input(b_fi), .flatten_kernel(b_fk),
    .operands_valid(b_valid), .conv_start(b_cs), .operands_ack(b_ack), .busy(b_busy)
  );

  // Latency-3 BRAM models
  always @(posedge clk) begin
    if (b_in_en) b_in_p0 <= b_in_addr[7:0];
    b_in_p1   <= b_in_p0;
    b_in_dout <= b_in_p1;
    if (b_k_en) b_k_p0 <= b_k_addr;
    b_k_p1   <= b_k_p0;
    b_k_dout <= b_k_p1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One load on instance A (sel=0) or B (sel=1); optional extra load_start
  // pulse extra_at cycles after acceptance. Counts enables/conv_start until valid.
  task automatic do_load(input bit sel, input logic [14:0] tb, input logic [7:0] kb,
                         input bit rk, input int extra_at,
                         output int lat, output int n_in, output int n_k, output int n_cs);
    lat = -1; n_in = 0; n_k = 0; n_cs = 0;
    @(posedge clk); #1;
    if (sel) begin b_ls = 1'b1; b_tb = tb; b_kb = kb; b_rk = rk; end
    else     begin a_ls = 1'b1; a_tb = tb; a_kb = kb; a_rk = rk; end
    @(posedge clk); #1;
    a_ls = 1'b0; b_ls = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == extra_at) begin
        if (sel) begin b_ls = 1'b1; b_tb = 15'd100; end
        else     begin a_ls = 1'b1; a_tb = 15'd100; end
      end else begin
        a_ls = 1'b0; b_ls = 1'b0;
      end
      n_in += int'(sel ? b_in_en : a_in_en);
      n_k  += int'(sel ? b_k_en  : a_k_en);
      n_cs += int'(sel ? b_cs    : a_cs);
      if (sel ? b_valid : a_valid) begin
        lat = k;
        break;
      end
    end
    a_ls = 1'b0; b_ls = 1'b0;
    @(posedge clk); #1;
    n_cs += int'(sel ? b_cs : a_cs);
    $display("load sel=%0d tile=0x%0h kern=0x%0h reload=%0d latency=%0d in_en=%0d k_en=%0d conv_start=%0d",
             sel, tb, kb, rk, lat, n_in, n_k, n_cs);
  endtask

  task automatic do_ack(input bit sel, input string tag);
    @(posedge clk); #1;
    if (sel) b_ack = 1'b1; else a_ack = 1'b1;
    @(posedge clk); #1;
    a_ack = 1'b0; b_ack = 1'b0;
    check({tag, "_valid"}, sel ? b_valid : a_valid, 0);
    check({tag, "_busy"},  sel ? b_busy  : a_busy,  0);
  endtask

  int lat, n_in, n_k, n_cs;
  logic [215:0] fk_saved;

  initial begin
    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", a_valid, 0);
    check("rst_busy",  a_busy,  0);
    check("rst_in_en", a_in_en, 0);
    check("rst_cs",    a_cs,    0);
    check("rst_fi",    |a_fi,   0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- load 1: base 0, reload kernel ----
    do_load(0, 15'd0, 8'd0, 1, -1, lat, n_in, n_k, n_cs);
    check("l1_lat",    lat, 49);
    check("l1_in_en",  n_in, 48);
    check("l1_k_en",   n_k, 27);
    check("l1_cs",     n_cs, 1);
    check("l1_fi_msb", a_fi[383 -: 8], 8'h00);
    check("l1_fi_e5",  a_fi[343 -: 8], 8'h05);
    check("l1_fi_lsb", a_fi[7:0], 8'h2F);
    check("l1_fk_msb", a_fk[215 -: 8], 8'h00);
    check("l1_fk_lsb", a_fk[7:0], 8'h1A);
    do_ack(0, "l1_ack");

    // ---- load 2: cached kernel ----
    fk_saved = a_fk;
    do_load(0, 15'd48, 8'd0, 0, -1, lat, n_in, n_k, n_cs);
    check("l2_lat",    lat, 49);
    check("l2_k_en",   n_k, 0);
    check("l2_fk_hold", (a_fk == fk_saved), 1);
    check("l2_fi_msb", a_fi[383 -: 8], 8'h30);
    check("l2_fi_lsb", a_fi[7:0], 8'h5F);
    do_ack(0, "l2_ack");

    // ---- instance B: latency 3, N=9 ----
    do_load(1, 15'd0, 8'd0, 1, -1, lat, n_in, n_k, n_cs);
    check("b_lat",   lat, 12);
    check("b_in_en", n_in, 4);
    check("b_k_en",  n_k, 9);
    check("b_cs",    n_cs, 1);
    check("b_fi",    b_fi, 32'h00010203);
    check("b_fk_msb", b_fk[71 -: 8], 8'h00);
    check("b_fk_lsb", b_fk[7:0], 8'h08);
    do_ack(1, "b_ack");

    // ---- address wrap ----
    do_load(0, 15'h7FFE, 8'hF0, 1, -1, lat, n_in, n_k, n_cs);
    check("w_lat",    lat, 49);
    check("w_fi_e0",  a_fi[383 -: 8], 8'hFE);
    check("w_fi_e1",  a_fi[375 -: 8], 8'hFF);
    check("w_fi_e2",  a_fi[367 -: 8], 8'h00);
    check("w_fi_lsb", a_fi[7:0], 8'h2D);
    check("w_fk_msb", a_fk[215 -: 8], 8'hF0);
    check("w_fk_lsb", a_fk[7:0], 8'h0A);
    do_ack(0, "w_ack");

    // ---- asynchronous reset mid-FETCH ----
    @(posedge clk); #1;
    a_ls = 1'b1; a_tb = 15'd0; a_kb = 8'd0; a_rk = 1'b1;
    @(posedge clk); #1;
    a_ls = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("ab_valid",   a_valid, 0);
    check("ab_busy",    a_busy, 0);
    check("ab_in_en",   a_in_en, 0);
    check("ab_k_en",    a_k_en, 0);
    check("ab_in_addr", a_in_addr, 0);
    check("ab_cs",      a_cs, 0);
    check("ab_fi",      |a_fi, 0);
    check("ab_fk",      |a_fk, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ab_post_busy", a_busy, 0);
    check("ab_post_cs",   a_cs, 0);

    // ---- fresh after reset, reload=0 still fetches kernel; stray pulse in FETCH ----
    do_load(0, 15'd0, 8'h10, 0, 5, lat, n_in, n_k, n_cs);
    check("f_lat",    lat, 49);
    check("f_k_en",   n_k, 27);
    check("f_cs",     n_cs, 1);
    check("f_fi_msb", a_fi[383 -: 8], 8'h00);
    check("f_fk_msb", a_fk[215 -: 8], 8'h10);
    check("f_fk_lsb", a_fk[7:0], 8'h2A);

    // ---- load_start in READY ignored ----
    @(posedge clk); #1;
    a_ls = 1'b1;
    @(posedge clk); #1;
    a_ls = 1'b0;
    check("rdy_valid", a_valid, 1);
    check("rdy_busy",  a_busy, 1);
    check("rdy_cs",    a_cs, 0);

    // ---- operands_ack coincident with load_start ----
    @(posedge clk); #1;
    a_ls = 1'b1; a_ack = 1'b1;
    @(posedge clk); #1;
    a_ls = 1'b0; a_ack = 1'b0;
    check("co_valid", a_valid, 0);
    check("co_busy",  a_busy, 0);
    @(posedge clk); #1;
    check("co_busy2", a_busy, 0);

    // ---- kernel now cached again ----
    do_load(0, 15'h10, 8'h55, 0, -1, lat, n_in, n_k, n_cs);
    check("c_lat",    lat, 49);
    check("c_k_en",   n_k, 0);
    check("c_fi_msb", a_fi[383 -: 8], 8'h10);
    check("c_fk_lsb", a_fk[7:0], 8'h2A);
    do_ack(0, "c_ack");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_operand_loader.md
Name: conv_operand_loader

Overview:
- Parametrised operand fetcher for the tiled convolution datapath.
- Streams an input tile (TILE_SIZE x TILE_SIZE x CHANNELS) and a kernel (KERNEL_SIZE x KERNEL_SIZE x CHANNELS) from two single-port BRAMs into flattened operand registers, then pulses conv_start.
- Compared with the fixed 4x4x3 loader, it adds:
  - configurable BRAM read latency
  - per-tile base addresses
  - kernel caching across tiles
  - a start/ack handshake so successive tiles can be loaded back to back.

Parameters:
- TILE_SIZE, 4, input tile edge length
- KERNEL_SIZE, 3, kernel edge length
- CHANNELS, 3, channel count
- DATA_WIDTH, 8, input element width
- KERNEL_WIDTH, 8, kernel element width
- IN_ADDR_WIDTH, 15, input BRAM address width
- K_ADDR_WIDTH, 8, kernel BRAM address width
- BRAM_LATENCY, 1, read latency of both BRAMs in cycles (legal range 1..3)
- Derived: IN_LEN = TILE_SIZE^2 * CHANNELS, K_LEN = KERNEL_SIZE^2 * CHANNELS

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- load_start  in  1  request a load; sampled only in IDLE
- tile_base_addr  in  IN_ADDR_WIDTH  input BRAM start address; sampled with load_start
- kernel_base_addr  in  K_ADDR_WIDTH  kernel BRAM start address; sampled with load_start
- reload_kernel  in  1  refetch the kernel; sampled with load_start
- in_en  out  1  input BRAM enable
- in_addr  out  IN_ADDR_WIDTH  input BRAM address
- in_dout  in  DATA_WIDTH  input BRAM read data
- k_en  out  1  kernel BRAM enable
- k_addr  out  K_ADDR_WIDTH  kernel BRAM address
- k_dout  in  KERNEL_WIDTH  kernel BRAM read data
- flatten_input  out  IN_LEN*DATA_WIDTH  flattened tile
- flatten_kernel  out  K_LEN*KERNEL_WIDTH  flattened kernel
- operands_valid  out  1  both operand registers are complete
- conv_start  out  1  single-cycle start pulse to the conv core
- operands_ack  in  1  consumer has latched the operands
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asserted asynchronously) clears all outputs and internal state to 0:
  - state=IDLE, all flatten bits, kernel_cached, counters, in_en/k_en, both addresses
  - reset mid-FETCH or mid-DRAIN aborts immediately; no partial data is flagged valid.
- States and transitions:
  - IDLE -> FETCH on load_start.
  - FETCH -> DRAIN after N issue cycles.
  - DRAIN -> READY after BRAM_LATENCY capture cycles.
  - READY -> IDLE on operands_ack.
- Kernel skip: do_k = reload_kernel OR NOT kernel_cached. Issue count N = IN_LEN if do_k=0, else max(IN_LEN, K_LEN).
- Acceptance edge E0 (load_start high in IDLE):
  - Register both base addresses and do_k.
  - Drive in_addr = tile_base_addr and in_en = 1.
  - If do_k: drive k_addr = kernel_base_addr and k_en = 1.
- Issue i (0..N-1) is presented in the cycle after edge E0+i.
  - in_en stays high for issues i < IN_LEN; k_en stays high for issues i < K_LEN when do_k.
  - Addresses are base + i, modulo 2^ADDR_WIDTH; wrap-around is legal.
- Capture of issue i happens at edge E0+i+1+BRAM_LATENCY, using a valid-tag delay line of depth BRAM_LATENCY.
  - Input element i goes to flatten_input[(IN_LEN-1-i)*DATA_WIDTH +: DATA_WIDTH].
  - Kernel element i goes to flatten_kernel[(K_LEN-1-i)*KERNEL_WIDTH +: KERNEL_WIDTH].
  - The first-fetched element therefore sits in the MSB slot.
- When do_k=0, flatten_kernel is untouched and k_en stays 0 for the whole load.
- The last capture occurs at edge E0+N+BRAM_LATENCY.
  - At that same edge: state=READY, operands_valid=1, kernel_cached set if do_k, conv_start=1 for exactly one cycle.
  - Latency from the acceptance edge to operands_valid is N+BRAM_LATENCY cycles.
- READY:
  - Flatten registers are held stable.
  - operands_valid clears on the edge that samples operands_ack high; the state returns to IDLE.
  - load_start in the same cycle as operands_ack is ignored; it is accepted the following cycle at the earliest.
- load_start outside IDLE is ignored, including in READY.
- operands_ack outside READY is ignored.
- Flatten registers keep their last value in IDLE and may change during FETCH/DRAIN. operands_valid=0 marks them invalid.
- conv_start is never asserted outside the READY-entry edge.

Test Plan:
- Defaults, BRAM model with latency 1, contents mem[a]=a: load_start, base 0, reload_kernel=1 ->
  - operands_valid rises 49 cycles after acceptance
  - flatten_input MSB byte = 0x00, LSB byte = 0x2F
  - flatten_kernel LSB byte = 0x1A
  - conv_start high exactly 1 cycle.
- Second load with tile_base_addr=48, reload_kernel=0 ->
  - k_en never asserted
  - flatten_kernel unchanged
  - flatten_input MSB byte = 0x30
  - latency 49 cycles.
- Fresh after reset, reload_kernel=0 -> kernel is still fetched, because kernel_cached=0.
- BRAM_LATENCY=3, TILE_SIZE=2, CHANNELS=1, KERNEL_SIZE=3 (N=9) ->
  - operands_valid 12 cycles after acceptance
  - k_en high 9 cycles, in_en high 4 cycles
  - data correct.
- tile_base_addr=0x7FFE with defaults -> addresses wrap 0x7FFE, 0x7FFF, 0x0000, ...; captured data matches the wrapped contents.
- Reset deasserted-then-reasserted asynchronously mid-FETCH; also load_start pulses in FETCH and READY, and operands_ack coincident with load_start ->
  - On reset: all outputs 0 immediately, no conv_start.
  - Extra load_start pulses are ignored.
  - After the coincident operands_ack/load_start: IDLE first, the new load is not accepted in that cycle.
